game_trace_buffer: RTL

Parametrised debug capture block for the Tetris game datapath. It samples NUM_CH game-side debug channels plus a free-running tick count once per game tick. Samples go into a DEPTH-entry circular buffer with a mask/value trigger, a configurable post-trigger window and a freeze-on-done state. It sits beside game_executioner in the game_clk domain and replaces ad-hoc sig1..sig6 probing with a frozen history that the decoder or SPI path reads back by logical index.

---
 rtl/game_trace_buffer.sv | 152 +++++++++++++++
 1 files changed

// File: rtl/game_trace_buffer.sv
//==============================================================================
// Module   : game_trace_buffer
// Brief    : Circular debug-capture buffer with mask/value trigger, post-trigger
//            window and freeze-on-done; read back by logical index.
// Revision : 1.0 - initial release
//==============================================================================
`timescale 1ns/1ps
`default_nettype none

module game_trace_buffer #(
    parameter int NUM_CH    = 7,
    parameter int SIG_W     = 9,
    parameter int DEPTH     = 16,
    parameter int POST_TRIG = 8,
    parameter int TICK_W    = 16
) (
    input  logic                              game_clk,
    input  logic                              reset_n,
    input  logic [NUM_CH*SIG_W-1:0]           sig_in,
    input  logic                              arm,
    input  logic                              force_trigger,
    input  logic [$clog2(NUM_CH)-1:0]         trig_ch,
    input  logic [SIG_W-1:0]                  trig_value,
    input  logic [SIG_W-1:0]                  trig_mask,
    input  logic [$clog2(DEPTH)-1:0]          rd_addr,
    output logic [TICK_W+NUM_CH*SIG_W-1:0]    rd_data,
    output logic [1:0]                        state,
    output logic                              done,
    output logic [$clog2(DEPTH):0]            fill_count,
    output logic [$clog2(DEPTH)-1:0]          trig_index,
    output logic [TICK_W-1:0]                 tick_count
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_FW = c_AW + 1;
    localparam int c_DW = TICK_W + NUM_CH * SIG_W;

    localparam logic [1:0] c_IDLE     = 2'd0;
    localparam logic [1:0] c_PRETRIG  = 2'd1;
    localparam logic [1:0] c_POSTTRIG = 2'd2;
    localparam logic [1:0] c_DONE     = 2'd3;

    logic [1:0]        r_state;
    logic [1:0]        w_state_next;
    logic [c_AW-1:0]   r_wr_ptr;
    logic [c_FW-1:0]   r_fill;
    logic [c_AW-1:0]   r_post_cnt;
    logic [c_AW-1:0]   r_trig_idx;
    logic [TICK_W-1:0] r_tick;
    logic [c_DW-1:0]   r_rd_data;
    logic [c_DW-1:0]   r_mem [DEPTH];

    logic [SIG_W-1:0]  w_sel;
    logic              w_hit;
    logic              w_write;
    logic              w_enter_done;
    logic [c_FW-1:0]   w_fill_inc;
    logic [c_AW-1:0]   w_start;
    logic [c_AW-1:0]   w_phys;

    // Channels past NUM_CH leave the compare disabled; only force can fire.
    always_comb begin
        w_sel = '0;
        w_hit = force_trigger;
        for (int c = 0; c < NUM_CH; c++) begin
            if (int'(trig_ch) == c) begin
                w_sel = sig_in[c*SIG_W +: SIG_W];
                w_hit = force_trigger | (((sig_in[c*SIG_W +: SIG_W] ^ trig_value) & trig_mask) == '0);
            end
        end
    end

    always_comb begin
        w_state_next = r_state;
        if (arm) begin
            w_state_next = c_PRETRIG;
        end else begin
            case (r_state)
                c_PRETRIG: begin
                    if (w_hit) begin
                        w_state_next = (POST_TRIG == 0) ? c_DONE : c_POSTTRIG;
                    end
                end
                c_POSTTRIG: begin
                    if (r_post_cnt == c_AW'(1)) begin
                        w_state_next = c_DONE;
                    end
                end
                default: w_state_next = r_state;
            endcase
        end
    end

    assign w_write      = !arm && ((r_state == c_PRETRIG) || (r_state == c_POSTTRIG));
    assign w_enter_done = w_write && (w_state_next == c_DONE);
    assign w_fill_inc   = (r_fill == c_FW'(DEPTH)) ? r_fill : r_fill + c_FW'(1);
    assign w_start      = (r_fill == c_FW'(DEPTH)) ? r_wr_ptr : '0;
    assign w_phys       = w_start + rd_addr;

    always_ff @(posedge game_clk) begin
        if (!reset_n) begin
            r_state    <= c_IDLE;
            r_wr_ptr   <= '0;
            r_fill     <= '0;
            r_post_cnt <= '0;
            r_trig_idx <= '0;
            r_tick     <= '0;
            r_rd_data  <= '0;
        end else begin
            r_state <= w_state_next;
            r_tick  <= r_tick + TICK_W'(1);
            if (arm) begin
                r_wr_ptr   <= '0;
                r_fill     <= '0;
                r_post_cnt <= c_AW'(POST_TRIG);
                r_trig_idx <= '0;
            end else if (w_write) begin
                r_wr_ptr <= r_wr_ptr + c_AW'(1);
                r_fill   <= w_fill_inc;
                if (r_state == c_POSTTRIG) begin
                    r_post_cnt <= r_post_cnt - c_AW'(1);
                end
                // Modulo-DEPTH arithmetic keeps the full-buffer case correct.
                if (w_enter_done) begin
                    r_trig_idx <= w_fill_inc[c_AW-1:0] - c_AW'(1) - c_AW'(POST_TRIG);
                end
            end
            if ({1'b0, rd_addr} >= r_fill) begin
                r_rd_data <= '0;
            end else begin
                r_rd_data <= r_mem[w_phys];
            end
        end
    end

    // Storage is left uninitialised so it maps onto RAM.
    always_ff @(posedge game_clk) begin
        if (reset_n && w_write) begin
            r_mem[r_wr_ptr] <= {r_tick, sig_in};
        end
    end

    assign rd_data    = r_rd_data;
    assign state      = r_state;
    assign done       = (r_state == c_DONE);
    assign fill_count = r_fill;
    assign trig_index = r_trig_idx;
    assign tick_count = r_tick;

endmodule

`default_nettype wire
